// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs feeding one registered CDB broadcast per cycle.
// Build option: define CDB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module cdb_arbiter #(
    parameter int                N_SRC       = 4,
    parameter int                DEPTH       = 2,
    parameter int                TAG_W       = 4,
    parameter logic [TAG_W-1:0]  TAG_INVALID = {TAG_W{1'b0}}
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_SRC-1:0]           SRC_VALID,
    input  logic [N_SRC*TAG_W-1:0]     SRC_TAG,
    input  logic [N_SRC*32-1:0]        SRC_DATA,
    output logic [N_SRC-1:0]           SRC_READY,
    output logic [TAG_W+31:0]          CDB_OUT,
    output logic                       CDB_VALID,
    output logic [$clog2(N_SRC)-1:0]   GRANT_IDX
);

    localparam int IDX_W = $clog2(N_SRC);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TAG_W + 32;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ENT_W-1:0]  mem_q    [N_SRC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [N_SRC];
    logic [PTR_W-1:0]  wr_ptr_d [N_SRC];
    logic [PTR_W-1:0]  rd_ptr_q [N_SRC];
    logic [PTR_W-1:0]  rd_ptr_d [N_SRC];
    logic [CNT_W-1:0]  cnt_q    [N_SRC];
    logic [CNT_W-1:0]  cnt_d    [N_SRC];
    logic [N_SRC-1:0]  ready_q;
    logic [N_SRC-1:0]  ready_d;
    logic [N_SRC-1:0]  push_s;
    logic [N_SRC-1:0]  pop_s;
    logic [N_SRC-1:0]  nonempty_s;

    logic              gnt_valid_s;
    logic [IDX_W-1:0]  gnt_idx_s;
    logic [ENT_W-1:0]  head_s;

    logic              cdb_valid_q;
    logic              cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [TAG_W-1:0]  cdb_tag_d;
    logic [31:0]       cdb_data_q;
    logic [31:0]       cdb_data_d;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  grant_d;

    // FIFO occupancy flags feed arbitration directly from registered counts.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            nonempty_s[i] = (cnt_q[i] != {CNT_W{1'b0}});
        end
    end

`ifdef CDB_FIXED_PRIORITY_EN
    // Fixed priority: scanning high to low leaves the lowest non-empty index as winner.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = {IDX_W{1'b0}};
        for (int k = N_SRC - 1; k >= 0; k--) begin
            gnt_idx_s   = nonempty_s[k] ? IDX_W'(k) : gnt_idx_s;
            gnt_valid_s = gnt_valid_s | nonempty_s[k];
        end
    end
`else
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  ptr_d;
    int                cand_s;

    // Round-robin: walking the scan order backwards leaves the first non-empty after ptr as winner.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = {IDX_W{1'b0}};
        cand_s      = 0;
        for (int k = N_SRC; k >= 1; k--) begin
            cand_s      = (int'(ptr_q) + k) % N_SRC;
            gnt_idx_s   = nonempty_s[cand_s] ? IDX_W'(cand_s) : gnt_idx_s;
            gnt_valid_s = gnt_valid_s | nonempty_s[cand_s];
        end
        ptr_d = gnt_valid_s ? gnt_idx_s : ptr_q;
    end

    // Round-robin pointer; reset to the last index so source 0 is scanned first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= IDX_W'(N_SRC - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Per-source push/pop and next-state pointers; ready is re-derived from next occupancy.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            push_s[i]   = SRC_VALID[i] & ready_q[i] &
                          (SRC_TAG[i*TAG_W +: TAG_W] != TAG_INVALID);
            pop_s[i]    = gnt_valid_s & (gnt_idx_s == IDX_W'(i));
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push_s[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop_s[i]);
            cnt_d[i]    = cnt_q[i] + CNT_W'(push_s[i]) - CNT_W'(pop_s[i]);
            ready_d[i]  = (cnt_d[i] != CNT_FULL);
        end
    end

    // Next CDB contents; data holds its last value when idle.
    always_comb begin
        head_s = mem_q[gnt_idx_s][rd_ptr_q[gnt_idx_s]];
        if (gnt_valid_s) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = head_s[ENT_W-1:32];
            cdb_data_d  = head_s[31:0];
            grant_d     = gnt_idx_s;
        end else begin
            cdb_valid_d = 1'b0;
            cdb_tag_d   = TAG_INVALID;
            cdb_data_d  = cdb_data_q;
            grant_d     = {IDX_W{1'b0}};
        end
    end

    // FIFO storage carries no reset: validity is tracked by the occupancy counters.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push_s[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {SRC_TAG[i*TAG_W +: TAG_W], SRC_DATA[i*32 +: 32]};
            end
        end
    end

    // FIFO control and registered CDB output.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr_q[i] <= {PTR_W{1'b0}};
                rd_ptr_q[i] <= {PTR_W{1'b0}};
                cnt_q[i]    <= {CNT_W{1'b0}};
            end
            ready_q     <= {N_SRC{1'b0}};
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= TAG_INVALID;
            cdb_data_q  <= 32'd0;
            grant_q     <= {IDX_W{1'b0}};
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            ready_q     <= ready_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            grant_q     <= grant_d;
        end
    end

    // Ready is forced low for the whole reset window, including the cycle reset is first raised.
    assign SRC_READY = ready_q & {N_SRC{~RST}};
    assign CDB_OUT   = {cdb_tag_q, cdb_data_q};
    assign CDB_VALID = cdb_valid_q;
    assign GRANT_IDX = grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-source expected queues popped by a CDB monitor.
module tb_cdb_arbiter;

    localparam logic [3:0] T_INV  = 4'd0;
    localparam logic [3:0] T_ALU  = 4'd1;
    localparam logic [3:0] T_BR   = 4'd2;
    localparam logic [3:0] T_LOAD = 4'd3;
    localparam logic [3:0] T_ST   = 4'd4;

    logic          CLK;
    logic          RST;
    logic [3:0]    SRC_VALID;
    logic [15:0]   SRC_TAG;
    logic [127:0]  SRC_DATA;
    logic [3:0]    SRC_READY;
    logic [35:0]   CDB_OUT;
    logic          CDB_VALID;
    logic [1:0]    GRANT_IDX;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic          mon_en = 1'b0;
    logic          log_en = 1'b0;
    logic [35:0]   exp0[$];
    logic [35:0]   exp1[$];
    logic [35:0]   exp2[$];
    logic [35:0]   exp3[$];
    int            g0_cyc[$];
    int            n_g3 = 0;
    logic          mon_have;
    logic [35:0]   mon_exp;

    cdb_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .SRC_VALID (SRC_VALID),
        .SRC_TAG   (SRC_TAG),
        .SRC_DATA  (SRC_DATA),
        .SRC_READY (SRC_READY),
        .CDB_OUT   (CDB_OUT),
        .CDB_VALID (CDB_VALID),
        .GRANT_IDX (GRANT_IDX)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic push_exp(input int s, input logic [3:0] tag, input logic [31:0] data);
        case (s)
            0: exp0.push_back({tag, data});
            1: exp1.push_back({tag, data});
            2: exp2.push_back({tag, data});
            3: exp3.push_back({tag, data});
            default: ;
        endcase
    endtask

    task automatic drive(input int s, input logic [3:0] tag, input logic [31:0] data);
        SRC_VALID[s]        = 1'b1;
        SRC_TAG[s*4 +: 4]   = tag;
        SRC_DATA[s*32 +: 32] = data;
    endtask

    // Scoreboard monitor: every broadcast must match the head of its source's expected queue.
    always @(negedge CLK) begin
        if (mon_en) begin
            n_cmp++;
            if (CDB_VALID === 1'b1) begin
                mon_have = 1'b0;
                mon_exp  = 36'd0;
                case (GRANT_IDX)
                    2'd0: if (exp0.size() > 0) begin mon_exp = exp0.pop_front(); mon_have = 1'b1; end
                    2'd1: if (exp1.size() > 0) begin mon_exp = exp1.pop_front(); mon_have = 1'b1; end
                    2'd2: if (exp2.size() > 0) begin mon_exp = exp2.pop_front(); mon_have = 1'b1; end
                    default: if (exp3.size() > 0) begin mon_exp = exp3.pop_front(); mon_have = 1'b1; end
                endcase
                if (!mon_have) begin
                    n_err++;
                    $display("FAIL bcast_unexpected: src %0d out %h, required no broadcast", GRANT_IDX, CDB_OUT);
                end else if (CDB_OUT !== mon_exp) begin
                    n_err++;
                    $display("FAIL bcast_data: src %0d out %h, required %h", GRANT_IDX, CDB_OUT, mon_exp);
                end
                if (log_en && GRANT_IDX == 2'd0) g0_cyc.push_back(cyc);
                if (log_en && GRANT_IDX == 2'd3) n_g3++;
            end else if (CDB_VALID !== 1'b0 || CDB_OUT[35:32] !== T_INV || GRANT_IDX !== 2'd0) begin
                n_err++;
                $display("FAIL idle: valid %b tag %h grant %0d, required 0/0/0", CDB_VALID, CDB_OUT[35:32], GRANT_IDX);
            end
        end
    end

    task automatic test_reset();
        RST = 1'b1;
        SRC_VALID = 4'hF;
        SRC_TAG = {T_ST, T_LOAD, T_BR, T_ALU};
        SRC_DATA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_cmp++; if (CDB_VALID !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", CDB_VALID); end
        n_cmp++; if (CDB_OUT !== 36'd0) begin n_err++; $display("FAIL rst_out: got %h, required 0", CDB_OUT); end
        n_cmp++; if (GRANT_IDX !== 2'd0) begin n_err++; $display("FAIL rst_grant: got %0d, required 0", GRANT_IDX); end
        n_cmp++; if (SRC_READY !== 4'h0) begin n_err++; $display("FAIL rst_ready: got %b, required 0000", SRC_READY); end
        mon_en = 1'b1;
        RST = 1'b0;
        SRC_VALID = 4'h0;
        @(negedge CLK);
        n_cmp++; if (SRC_READY !== 4'hF) begin n_err++; $display("FAIL rst_release_ready: got %b, required 1111", SRC_READY); end
    endtask

    task automatic test_round_robin();
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            drive(i, T_ALU + 4'(i), 32'h10 + 32'(i));
            push_exp(i, T_ALU + 4'(i), 32'h10 + 32'(i));
        end
        @(negedge CLK);
        SRC_VALID = 4'h0;
        n_cmp++; if (CDB_VALID !== 1'b0) begin n_err++; $display("FAIL rr_latency: valid %b, required 0", CDB_VALID); end
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (CDB_VALID !== 1'b1 || GRANT_IDX !== 2'(k)) begin
                n_err++;
                $display("FAIL rr_order: slot %0d valid %b grant %0d, required 1/%0d", k, CDB_VALID, GRANT_IDX, k);
            end
        end
        @(negedge CLK);
        n_cmp++; if (CDB_VALID !== 1'b0) begin n_err++; $display("FAIL rr_gap: valid %b, required 0", CDB_VALID); end
    endtask

    task automatic test_single();
        @(negedge CLK);
        drive(2, T_LOAD, 32'hDEADBEEF);
        push_exp(2, T_LOAD, 32'hDEADBEEF);
        @(negedge CLK);
        SRC_VALID = 4'h0;
        n_cmp++; if (CDB_VALID !== 1'b0) begin n_err++; $display("FAIL single_latency: valid %b, required 0", CDB_VALID); end
        @(negedge CLK);
        n_cmp++;
        if (CDB_VALID !== 1'b1 || CDB_OUT !== {T_LOAD, 32'hDEADBEEF} || GRANT_IDX !== 2'd2) begin
            n_err++;
            $display("FAIL single_bcast: valid %b out %h grant %0d, required 1/3deadbeef/2", CDB_VALID, CDB_OUT, GRANT_IDX);
        end
        @(negedge CLK);
        n_cmp++;
        if (CDB_VALID !== 1'b0 || CDB_OUT !== {T_INV, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL single_idle_hold: valid %b out %h, required 0/0deadbeef", CDB_VALID, CDB_OUT);
        end
    endtask

    task automatic test_invalid_tag();
        @(negedge CLK);
        drive(1, T_INV, 32'h55);
        @(negedge CLK);
        SRC_VALID = 4'h0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (SRC_READY[1] !== 1'b1 || CDB_VALID !== 1'b0) begin
                n_err++;
                $display("FAIL inv_tag: ready1 %b valid %b, required 1/0", SRC_READY[1], CDB_VALID);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_backpressure();
        int s0 = 0;
        int n1 = 0;
        int n3 = 0;
        logic saw_full = 1'b0;
        g0_cyc.delete();
        n_g3 = 0;
        log_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (s0 < 4) begin
                drive(0, T_ALU, 32'(s0 + 1));
                if (SRC_READY[0] === 1'b1) begin
                    push_exp(0, T_ALU, 32'(s0 + 1));
                    s0++;
                end else begin
                    saw_full = 1'b1;
                end
            end else begin
                SRC_VALID[0] = 1'b0;
            end
            drive(1, T_BR, 32'h100 + 32'(n1));
            if (SRC_READY[1] === 1'b1) begin push_exp(1, T_BR, 32'h100 + 32'(n1)); n1++; end
            drive(3, T_ST, 32'h300 + 32'(n3));
            if (SRC_READY[3] === 1'b1) begin push_exp(3, T_ST, 32'h300 + 32'(n3)); n3++; end
        end
        @(negedge CLK);
        SRC_VALID = 4'h0;
        log_en = 1'b0;
        for (int w = 0; w < 60; w++) begin
            if (exp0.size() + exp1.size() + exp3.size() == 0) break;
            @(negedge CLK);
        end
        n_cmp++; if (s0 != 4) begin n_err++; $display("FAIL bp_accepted: got %0d, required 4", s0); end
        n_cmp++;
        if (exp0.size() + exp1.size() + exp3.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain: left %0d/%0d/%0d, required 0/0/0", exp0.size(), exp1.size(), exp3.size());
        end
`ifdef CDB_FIXED_PRIORITY_EN
        n_cmp++; if (n_g3 != 0) begin n_err++; $display("FAIL bp_starve3: grants %0d, required 0", n_g3); end
`else
        n_cmp++; if (saw_full !== 1'b1) begin n_err++; $display("FAIL bp_full: ready0 drop %b, required 1", saw_full); end
        n_cmp++; if (g0_cyc.size() != 4) begin n_err++; $display("FAIL bp_g0_count: got %0d, required 4", g0_cyc.size()); end
        for (int k = 1; k < g0_cyc.size(); k++) begin
            n_cmp++;
            if (g0_cyc[k] - g0_cyc[k-1] != 3) begin
                n_err++;
                $display("FAIL bp_g0_period: gap %0d, required 3", g0_cyc[k] - g0_cyc[k-1]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        drive(0, T_ALU, 32'hBAD0);
        drive(1, T_BR, 32'hBAD1);
        drive(2, T_LOAD, 32'hBAD2);
        @(negedge CLK);
        SRC_VALID = 4'h0;
        RST = 1'b1;
        #1;
        n_cmp++; if (SRC_READY !== 4'h0) begin n_err++; $display("FAIL mid_rst_ready: got %b, required 0000", SRC_READY); end
        @(negedge CLK);
        RST = 1'b0;
        n_cmp++; if (CDB_VALID !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b, required 0", CDB_VALID); end
        @(negedge CLK);
        n_cmp++; if (SRC_READY !== 4'hF) begin n_err++; $display("FAIL mid_release_ready: got %b, required 1111", SRC_READY); end
        drive(3, T_ST, 32'hCAFE0001);
        push_exp(3, T_ST, 32'hCAFE0001);
        @(negedge CLK);
        SRC_VALID = 4'h0;
        @(negedge CLK);
        n_cmp++;
        if (CDB_VALID !== 1'b1 || CDB_OUT !== {T_ST, 32'hCAFE0001} || GRANT_IDX !== 2'd3) begin
            n_err++;
            $display("FAIL mid_first_bcast: valid %b out %h grant %0d, required 1/4cafe0001/3", CDB_VALID, CDB_OUT, GRANT_IDX);
        end
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        SRC_VALID = 4'h0;
        SRC_TAG = 16'd0;
        SRC_DATA = 128'd0;
        test_reset();
        test_round_robin();
        test_single();
        test_invalid_tag();
        test_backpressure();
        test_reset_mid();
        n_cmp++;
        if (exp0.size() + exp1.size() + exp2.size() + exp3.size() != 0) begin
            n_err++;
            $display("FAIL final_empty: %0d results never broadcast, required 0",
                     exp0.size() + exp1.size() + exp2.size() + exp3.size());
        end
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Collects tag/value results from the functional units (ALU, branch, load, store) and broadcasts them on the common data bus (CDB) to the reservation stations and map table.
- Each source has a small result FIFO. At most one entry wins arbitration per cycle and drives the registered CDB output. This is the producer of the cdb_t broadcast the reservation stations consume.
- FUs hand off a result and may then signal their reservation station done, even while the CDB is busy.

Parameters:
- N_SRC, 4, number of FU result sources (index 0 = ALU, 1 = branch, 2 = load, 3 = store/aux).
- DEPTH, 2, entries per source FIFO; power of two, >= 2.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- SRC_VALID  input  N_SRC  per-source result valid.
- SRC_TAG  input  N_SRC x RS_tag_type  per-source result tag (producing RS tag).
- SRC_DATA  input  N_SRC x 32  per-source result value.
- SRC_READY  output  N_SRC  per-source FIFO can accept.
- CDB_OUT  output  cdb_t  broadcast tag/data pair; tag = INVALID when idle.
- CDB_VALID  output  1  high when CDB_OUT carries a real result.
- GRANT_IDX  output  clog2(N_SRC)  source index of the current broadcast; 0 when idle.

Behaviour:
- Reset (RST=1 at a clock edge):
  - All FIFOs are emptied and the round-robin pointer is set to N_SRC-1, so source 0 is considered first.
  - CDB_VALID=0, CDB_OUT.tag=INVALID, CDB_OUT.data=0, GRANT_IDX=0.
  - SRC_READY=0 while RST is high and for the same-cycle inputs; SRC_READY=1 from the first cycle after RST deasserts.
  - A reset mid-operation discards all buffered results without broadcasting them.
- Accept:
  - Source i enqueues when SRC_VALID[i] && SRC_READY[i].
  - SRC_READY[i] = !full[i], registered from occupancy. When the FIFO is full, no accept happens even if the same cycle pops it.
  - SRC_VALID with SRC_TAG == INVALID is ignored: not enqueued, no error.
- Arbitration (combinational over FIFO heads, once per cycle):
  - Scan sources starting at ptr+1 modulo N_SRC; the first non-empty FIFO wins.
  - On a grant, pop its head and set ptr to the winner. If nothing is granted, ptr holds.
- Output:
  - The winner's head is registered into CDB_OUT/CDB_VALID/GRANT_IDX at the clock edge.
  - Latency: a result accepted at edge N is broadcast no earlier than the cycle after edge N+1. There is no combinational input-to-CDB path.
  - Idle cycle: CDB_VALID=0, tag=INVALID, data holds its last value.
- Simultaneous events:
  - Enqueue and pop on the same non-full FIFO in one cycle: occupancy is unchanged and order is preserved.
  - All sources valid every cycle: grants rotate 0,1,2,3,0,...
- Fairness: a non-empty source is granted within N_SRC cycles.
- FIFO pointers wrap modulo DEPTH. Occupancy counters are clog2(DEPTH)+1 bits and never exceed DEPTH.
- Ordering: results from one source are broadcast in acceptance order. There is no ordering guarantee across sources.

Optional Feature:
- CDB_FIXED_PRIORITY_EN
  - Defined: arbitration is fixed priority, with the lowest source index winning. ptr is removed, and a continuously busy low index may starve higher indices.
  - Undefined: round-robin exactly as specified above.
- Ports and latency are identical in both builds.

Test Plan:
- Reset: hold RST 2 cycles with SRC_VALID=4'b1111 -> CDB_VALID=0, tag=INVALID, GRANT_IDX=0, SRC_READY=0 during reset; SRC_READY=4'b1111 on the first cycle after release; nothing broadcast.
- Single result: source 2 sends tag=LOAD, data=0xDEADBEEF for one cycle at edge N -> in the cycle after edge N+1, CDB_VALID=1, tag=LOAD, data=0xDEADBEEF, GRANT_IDX=2; idle (tag=INVALID) the following cycle.
- Round-robin: all four sources enqueue one result each in the same cycle (data 0x10,0x11,0x12,0x13) -> four consecutive broadcasts with GRANT_IDX 0,1,2,3, data in that order, with no gaps. With CDB_FIXED_PRIORITY_EN the same stimulus gives the same order.
- Backpressure:
  - Source 0 presents 4 results back-to-back while sources 1 and 3 stay continuously busy.
  - Source 0 FIFO fills and SRC_READY[0] drops to 0.
  - All 4 values are still broadcast in order (0x1,0x2,0x3,0x4) with no loss or duplicate.
  - Round-robin: source 0 is granted every 3rd cycle. Fixed priority: source 3 starves while sources 0 and 1 are busy.
- INVALID tag: source 1 asserts SRC_VALID with SRC_TAG=INVALID, data=0x55 -> no enqueue, no broadcast, SRC_READY[1] stays 1.
- Reset mid-operation: 3 results buffered and RST pulsed for 1 cycle -> no buffered result ever appears on CDB; first post-reset broadcast is a newly accepted result.
